// File: rtl/grf_wport_arbiter.sv
// GRF write-port arbiter: writeback has priority, long-latency results queue in a FIFO.
// Optional GRF_ARB_FWD_EN adds same-cycle write-to-read bypass outputs.
module grf_wport_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_we,
    input  logic [4:0]               a_addr,
    input  logic [31:0]              a_wd,
    input  logic                     b_valid,
    input  logic [4:0]               b_addr,
    input  logic [31:0]              b_wd,
    output logic                     b_ready,
    output logic                     grf_we,
    output logic [4:0]               grf_a3,
    output logic [31:0]              grf_wd,
    input  logic [4:0]               r1_addr,
    input  logic [4:0]               r2_addr,
    output logic                     pend1,
    output logic                     pend2,
    output logic                     stall_req,
`ifdef GRF_ARB_FWD_EN
    output logic                     fwd1_hit,
    output logic [31:0]              fwd1_data,
    output logic                     fwd2_hit,
    output logic [31:0]              fwd2_data,
`endif
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    st_q, st_d;

    logic a_act, full, nempty, head_vld, push, pop, hit1, hit2;

    assign a_act    = a_we && (a_addr != 5'd0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign nempty   = (cnt_q != '0);
    assign head_vld = nempty && vld_q[rp_q];
    assign b_ready  = reset && !full;
    assign push     = b_valid && b_ready && (b_addr != 5'd0);
    // Squashed heads still occupy a slot and are retired whenever A is idle.
    assign pop      = reset && !a_act && nempty;
    assign q_count  = cnt_q;

    assign stall_req = reset && ((st_q >= SW'(STARVE_LIMIT)) || full);

    always_comb begin
        grf_we = 1'b0;
        grf_a3 = 5'd0;
        grf_wd = 32'd0;
        if (reset && a_act) begin
            grf_we = 1'b1;
            grf_a3 = a_addr;
            grf_wd = a_wd;
        end else if (reset && head_vld) begin
            grf_we = 1'b1;
            grf_a3 = addr_q[rp_q];
            grf_wd = data_q[rp_q];
        end
    end

    always_comb begin
        vld_d = vld_q;
        if (a_act) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == a_addr) vld_d[i] = 1'b0;
            end
        end
        if (pop)  vld_d[rp_q] = 1'b0;
        if (push) vld_d[wp_q] = 1'b1;
    end

    always_comb begin
        hit1 = push && (b_addr == r1_addr);
        hit2 = push && (b_addr == r2_addr);
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && addr_q[i] == r1_addr) hit1 = 1'b1;
            if (vld_q[i] && addr_q[i] == r2_addr) hit2 = 1'b1;
        end
        pend1 = (r1_addr != 5'd0) && hit1;
        pend2 = (r2_addr != 5'd0) && hit2;
    end

    always_comb begin
        wp_d  = push ? wp_q + AW'(1) : wp_q;
        rp_d  = pop  ? rp_q + AW'(1) : rp_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (!nempty || pop)
            st_d = '0;
        else if (st_q < SW'(STARVE_LIMIT))
            st_d = st_q + SW'(1);
        else
            st_d = st_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            st_q  <= '0;
        end else begin
            vld_q <= vld_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            st_q  <= st_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wp_q] <= b_addr;
            data_q[wp_q] <= b_wd;
        end
    end

`ifdef GRF_ARB_FWD_EN
    assign fwd1_hit  = grf_we && (grf_a3 == r1_addr) && (r1_addr != 5'd0);
    assign fwd2_hit  = grf_we && (grf_a3 == r2_addr) && (r2_addr != 5'd0);
    assign fwd1_data = grf_wd;
    assign fwd2_data = grf_wd;
`endif

endmodule

// File: doc/grf_wport_arbiter.md
Name: grf_wport_arbiter

Overview:
- Arbitrates the single GRF write port (WE/A3/WD) between two requesters:
  - the pipeline writeback stage (requester A);
  - a long-latency unit such as the multiply/divide unit (requester B).
- A has absolute priority and is never back-pressured.
- B results are queued in a small in-order FIFO and drained into free write-port cycles.
- The block also reports pending-write hits to the hazard unit and raises a bubble request when B is starved.

Parameters:
- DEPTH, 4: B queue entries, power of two, 2..8.
- STARVE_LIMIT, 8: cycles a non-empty queue may go without a drain before stall_req asserts.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_we  in  1  writeback write enable.
- a_addr  in  5  writeback destination register.
- a_wd  in  32  writeback data.
- b_valid  in  1  B result valid.
- b_addr  in  5  B destination register.
- b_wd  in  32  B data.
- b_ready  out  1  queue can accept a B beat.
- grf_we  out  1  to GRF WE.
- grf_a3  out  5  to GRF A3.
- grf_wd  out  32  to GRF WD.
- r1_addr  in  5  decode read address 1.
- r2_addr  in  5  decode read address 2.
- pend1  out  1  r1_addr has a queued B write.
- pend2  out  1  r2_addr has a queued B write.
- stall_req  out  1  ask upstream to insert one writeback bubble.
- q_count  out  log2(DEPTH)+1  occupied entries.

Behaviour:
- Reset: while reset=0, asynchronously:
  - queue emptied, all entry valid bits cleared, starvation counter cleared;
  - grf_we=0, b_ready=0, pend1/2=0, stall_req=0, q_count=0.
  - A beat in flight when reset asserts is lost.
- a_act = a_we && a_addr!=0. A write with a_addr==0 is dropped and never reaches grf_we.
- B handshake:
  - A beat is accepted on a rising edge with b_valid && b_ready.
  - b_ready = (q_count < DEPTH), evaluated at cycle start; no push while full, even if a pop occurs in the same cycle.
  - An accepted beat with b_addr==0 is discarded and not enqueued.
- Write-port select (combinational):
  - if a_act: grf_we=1, a3=a_addr, wd=a_wd;
  - else if the queue head is valid: grf_we=1, a3=head addr, wd=head data; the head pops at the edge;
  - else grf_we=0, a3=0, wd=0.
  - A stored entry whose valid bit was cleared is popped silently in one cycle with grf_we=0.
- Latency: a B beat is never written in its acceptance cycle. The earliest write is the cycle after acceptance, if a_act=0.
- Ordering:
  - A is program-order younger than every stored entry.
  - When a_act, every stored entry with addr==a_addr has its valid bit cleared at the edge (squash).
  - A beat accepted in that same cycle is not squashed.
  - B entries drain strictly FIFO.
- pend1 = r1_addr!=0 && a valid stored entry or the incoming accepted beat matches r1_addr. pend2 is the same for r2_addr.
- Starvation:
  - The counter increments each cycle the queue is non-empty and does not pop.
  - It resets on any pop or when the queue is empty.
  - stall_req=1 when counter>=STARVE_LIMIT or q_count==DEPTH; it clears the cycle after a pop.
- Pointers: read and write pointers wrap modulo DEPTH. q_count is updated as +push −pop, so a simultaneous push and pop leaves it unchanged.

Optional Feature:
- GRF_ARB_FWD_EN defined:
  - extra outputs fwd1_hit/fwd1_data and fwd2_hit/fwd2_data.
  - fwdN_hit = grf_we && grf_a3==rN_addr && rN_addr!=0; fwdN_data = grf_wd.
  - This gives same-cycle write-to-read bypass for decode.
- Not defined: these ports are absent, and decode relies on the GRF being read after the write edge.

Test Plan:
- Reset low mid-drain with q_count=3 -> grf_we=0, b_ready=0, q_count=0 immediately. After release, b_ready=1 and no stale write appears.
- B beat (addr 5, 0x1234) while a_we=0 -> next cycle grf_we=1, a3=5, wd=0x1234; q_count returns to 0.
- A writes every cycle (addr 3) while B pushes 4 beats -> b_ready=0 after the 4th beat, stall_req=1, no B writes. On the first a_we=0 cycle the head drains, in push order.
- Queue holds addr 7; A writes addr 7 = 0xAAAA -> the entry is squashed; the GRF ends with 0xAAAA and grf_we never re-asserts for 7.
- A or B targeting addr 0 -> grf_we stays 0 and q_count is unchanged.
- Queue holds addr 9; r1_addr=9, r2_addr=0 -> pend1=1, pend2=0. pend1 drops the cycle after addr 9 drains.
